// File: rtl/pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : pipe_control_unit
// Brief   : ID-stage decoder with ID/EX, EX/MEM and MEM/WB control registers,
//           load-use stall, IF/ID flush and a multi-cycle MADDU sequencer.
// Revision: 1.0  initial release
// ============================================================================
module pipe_control_unit #(
    parameter int MADDU_LAT = 4,
    parameter int RADDR_W   = 5,
    parameter int LU_DETECT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Opcode,
    input  logic [RADDR_W-1:0] IfId_Rs,
    input  logic [RADDR_W-1:0] IfId_Rt,
    input  logic [RADDR_W-1:0] IdEx_Rt,
    input  logic               BrTaken,
    output logic               Branch,
    output logic               Jump,
    output logic               ExtendSel,
    output logic               Illegal,
    output logic               PcWrite,
    output logic               IfIdWrite,
    output logic               IfIdFlush,
    output logic [7:0]         IdEx_Ctrl,
    output logic [3:0]         ExMem_Ctrl,
    output logic [1:0]         MemWb_Ctrl,
    output logic               MaddBusy
);

    localparam int CNT_W = (MADDU_LAT > 1) ? $clog2(MADDU_LAT) : 1;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MADD = 1'b1} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_idex_ctrl;
    logic               r_idex_madd;
    logic [3:0]         r_exmem_ctrl;
    logic [1:0]         r_memwb_ctrl;

    logic [7:0]         w_bundle;
    logic               w_is_madd;
    logic               w_busy;
    logic               w_lu;

    always_comb begin
        w_bundle  = 8'h00;
        Branch    = 1'b0;
        Jump      = 1'b0;
        ExtendSel = 1'b0;
        Illegal   = 1'b0;
        case (Opcode)
            6'd0, 6'd28: w_bundle = 8'b1100_0010;
            6'd9: begin
                w_bundle  = 8'b0001_0010;
                ExtendSel = 1'b1;
            end
            6'd35: begin
                w_bundle  = 8'b0001_1011;
                ExtendSel = 1'b1;
            end
            6'd43: begin
                w_bundle  = 8'b0001_0100;
                ExtendSel = 1'b1;
            end
            6'd4: begin
                w_bundle  = 8'b0010_0000;
                ExtendSel = 1'b1;
                Branch    = 1'b1;
            end
            6'd2: begin
                ExtendSel = 1'b1;
                Jump      = 1'b1;
            end
            default: Illegal = 1'b1;
        endcase
    end

    assign w_is_madd = (Opcode == 6'd28);

    // A MADDU in EX freezes the front end until its counter drains to zero.
    assign w_busy = (r_state == S_MADD) && (r_cnt != '0) && r_idex_madd;

    assign w_lu = (LU_DETECT != 0) && r_idex_ctrl[3] && (IdEx_Rt != '0) &&
                  ((IdEx_Rt == IfId_Rs) || (IdEx_Rt == IfId_Rt)) && !w_busy;

    assign PcWrite    = !(w_busy || w_lu);
    assign IfIdWrite  = !(w_busy || w_lu);
    assign IfIdFlush  = !w_busy && !w_lu && (Jump || (Branch && BrTaken));
    assign MaddBusy   = w_busy;
    assign IdEx_Ctrl  = r_idex_ctrl;
    assign ExMem_Ctrl = r_exmem_ctrl;
    assign MemWb_Ctrl = r_memwb_ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idex_ctrl  <= 8'h00;
            r_idex_madd  <= 1'b0;
            r_exmem_ctrl <= 4'h0;
            r_memwb_ctrl <= 2'b00;
        end else if (w_busy) begin
            r_cnt        <= r_cnt - CNT_W'(1);
            r_exmem_ctrl <= 4'h0;
            r_memwb_ctrl <= r_exmem_ctrl[1:0];
        end else if (w_lu) begin
            r_state      <= S_IDLE;
            r_idex_ctrl  <= 8'h00;
            r_idex_madd  <= 1'b0;
            r_exmem_ctrl <= r_idex_ctrl[3:0];
            r_memwb_ctrl <= r_exmem_ctrl[1:0];
        end else begin
            r_idex_ctrl  <= w_bundle;
            r_idex_madd  <= w_is_madd;
            r_exmem_ctrl <= r_idex_ctrl[3:0];
            r_memwb_ctrl <= r_exmem_ctrl[1:0];
            if (w_is_madd && (MADDU_LAT > 1)) begin
                r_state <= S_MADD;
                r_cnt   <= CNT_W'(MADDU_LAT - 1);
            end else begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_control_unit
// Brief   : Directed plus randomized bench for pipe_control_unit against a
//           stage-occupancy reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_pipe_control_unit;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic [4:0] IfId_Rs, IfId_Rt, IdEx_Rt;
    logic       BrTaken;
    logic       Branch, Jump, ExtendSel, Illegal, PcWrite, IfIdWrite, IfIdFlush, MaddBusy;
    logic [7:0] IdEx_Ctrl;
    logic [3:0] ExMem_Ctrl;
    logic [1:0] MemWb_Ctrl;

    int n_cmp = 0;
    int n_err = 0;
    int busy_seen = 0;

    // reference model: control word resident in each stage, plus remaining freeze cycles
    logic [7:0] m_ex;
    logic [3:0] m_mem;
    logic [1:0] m_wb;
    int         m_left;

    pipe_control_unit #(.MADDU_LAT(LAT), .RADDR_W(5), .LU_DETECT(1)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .IfId_Rs(IfId_Rs), .IfId_Rt(IfId_Rt),
        .IdEx_Rt(IdEx_Rt), .BrTaken(BrTaken), .Branch(Branch), .Jump(Jump),
        .ExtendSel(ExtendSel), .Illegal(Illegal), .PcWrite(PcWrite), .IfIdWrite(IfIdWrite),
        .IfIdFlush(IfIdFlush), .IdEx_Ctrl(IdEx_Ctrl), .ExMem_Ctrl(ExMem_Ctrl),
        .MemWb_Ctrl(MemWb_Ctrl), .MaddBusy(MaddBusy)
    );

    always #5 clk = ~clk;

    // {Illegal, Branch, Jump, ExtendSel, bundle}
    function automatic logic [11:0] ref_decode(input logic [5:0] op);
        case (op)
            6'd0, 6'd28: return {4'b0000, 8'b1100_0010};
            6'd9:        return {4'b0001, 8'b0001_0010};
            6'd35:       return {4'b0001, 8'b0001_1011};
            6'd43:       return {4'b0001, 8'b0001_0100};
            6'd4:        return {4'b0101, 8'b0010_0000};
            6'd2:        return {4'b0011, 8'b0000_0000};
            default:     return {4'b1000, 8'b0000_0000};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] xrt, input logic br);
        logic [11:0] d;
        logic        busy, lu, fl;
        rst_n = rn; Opcode = op; IfId_Rs = rs; IfId_Rt = rt; IdEx_Rt = xrt; BrTaken = br;
        @(negedge clk);
        d    = ref_decode(op);
        busy = (m_left > 0);
        lu   = !busy && m_ex[3] && (xrt != 0) && (xrt == rs || xrt == rt);
        fl   = !busy && !lu && (d[9] || (d[10] && br));
        chk("Illegal",    {7'd0, Illegal},    {7'd0, d[11]});
        chk("Branch",     {7'd0, Branch},     {7'd0, d[10]});
        chk("Jump",       {7'd0, Jump},       {7'd0, d[9]});
        chk("ExtendSel",  {7'd0, ExtendSel},  {7'd0, d[8]});
        chk("PcWrite",    {7'd0, PcWrite},    {7'd0, !(busy || lu)});
        chk("IfIdWrite",  {7'd0, IfIdWrite},  {7'd0, !(busy || lu)});
        chk("IfIdFlush",  {7'd0, IfIdFlush},  {7'd0, fl});
        chk("MaddBusy",   {7'd0, MaddBusy},   {7'd0, busy});
        chk("IdEx_Ctrl",  IdEx_Ctrl,          m_ex);
        chk("ExMem_Ctrl", {4'd0, ExMem_Ctrl}, {4'd0, m_mem});
        chk("MemWb_Ctrl", {6'd0, MemWb_Ctrl}, {6'd0, m_wb});
        if (MaddBusy === 1'b1) busy_seen++;
        @(posedge clk);
        if (!rn) begin
            m_ex = 8'h00; m_mem = 4'h0; m_wb = 2'b00; m_left = 0;
        end else if (busy) begin
            m_wb = m_mem[1:0]; m_mem = 4'h0; m_left--;
        end else if (lu) begin
            m_wb = m_mem[1:0]; m_mem = m_ex[3:0]; m_ex = 8'h00;
        end else begin
            m_wb = m_mem[1:0]; m_mem = m_ex[3:0]; m_ex = d[7:0];
            m_left = (op == 6'd28) ? LAT - 1 : 0;
        end
        #1;
    endtask

    initial begin
        logic [5:0] ops [9];
        m_ex = 8'hFF; m_mem = 4'hF; m_wb = 2'b11; m_left = 0;
        ops[0] = 6'd0; ops[1] = 6'd28; ops[2] = 6'd9; ops[3] = 6'd35; ops[4] = 6'd43;
        ops[5] = 6'd4; ops[6] = 6'd2;  ops[7] = 6'd35; ops[8] = 6'd63;
        rst_n = 1'b0; Opcode = 6'd0; IfId_Rs = '0; IfId_Rt = '0; IdEx_Rt = '0; BrTaken = 1'b0;
        @(posedge clk); #1;
        m_ex = 8'h00; m_mem = 4'h0; m_wb = 2'b00;
        step(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);

        // decode table and 3-edge drain to MEM/WB
        step(1'b1, 6'd35, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd43, 5'd3, 5'd4, 5'd0, 1'b0);
        step(1'b1, 6'd9,  5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd4,  5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd2,  5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd0,  5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd0,  5'd1, 5'd2, 5'd0, 1'b0);

        // load-use stall, then resume; rt=0 never stalls
        step(1'b1, 6'd35, 5'd1, 5'd5, 5'd0, 1'b0);
        step(1'b1, 6'd0,  5'd5, 5'd6, 5'd5, 1'b0);
        step(1'b1, 6'd0,  5'd5, 5'd6, 5'd5, 1'b0);
        step(1'b1, 6'd35, 5'd1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 6'd0,  5'd0, 5'd6, 5'd0, 1'b0);

        // flush on taken branch / jump
        step(1'b1, 6'd4, 5'd1, 5'd2, 5'd0, 1'b1);
        step(1'b1, 6'd4, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd2, 5'd1, 5'd2, 5'd0, 1'b0);

        // MADDU occupies EX for LAT cycles
        busy_seen = 0;
        step(1'b1, 6'd28, 5'd1, 5'd2, 5'd0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 6'd9, 5'd1, 5'd2, 5'd0, 1'b0);
        n_cmp++;
        assert (busy_seen == LAT - 1) else begin
            n_err++;
            $error("FAIL madd_busy_cycles observed=%0d expected=%0d", busy_seen, LAT - 1);
        end

        // illegal opcode, then reset in the middle of a MADDU
        step(1'b1, 6'd63, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd28, 5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd0,  5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b0, 6'd0,  5'd1, 5'd2, 5'd0, 1'b0);
        step(1'b1, 6'd0,  5'd1, 5'd2, 5'd0, 1'b0);

        // load-use beats a taken branch; branch flushes once the stall clears
        step(1'b1, 6'd35, 5'd1, 5'd5, 5'd0, 1'b0);
        step(1'b1, 6'd4,  5'd5, 5'd7, 5'd5, 1'b1);
        step(1'b1, 6'd4,  5'd5, 5'd7, 5'd5, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] xr, rs, rt;
            xr = 5'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 49) != 0), ops[$urandom_range(0, 8)],
                 rs, rt, xr, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
